// File: rtl/mem_copy_master.sv
`default_nettype none
// ============================================================================
//  Module   : mem_copy_master
//  Purpose  : Initiator for the single-port memory valid/ready interface.
//             Copies len_i words from src_addr_i to dst_addr_i, one read then
//             one write per word, in ascending address order.
//  Ports    : clk_i, rst_i          - clock, synchronous active-high reset
//             start_i, src_addr_i,
//             dst_addr_i, len_i     - command (sampled in IDLE only)
//             busy_o, done_o, err_o - command status
//             valid_o, wr_rd_en_o,
//             addr_o, wdata_o       - memory request (1 = write, 0 = read)
//             rdata_i, ready_i      - memory response
//  Options  : MEMCPY_TIMEOUT_EN - when defined, a request that waits
//             TIMEOUT_CYCLES cycles for ready_i is abandoned and the command
//             ends with done_o and err_o. When undefined, err_o is tied 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_copy_master #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 32,
`ifdef MEMCPY_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 64,
`endif
  parameter int ADDR_WIDTH     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  valid_o,
  output logic                  wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic [WIDTH-1:0]      rdata_i,
  input  logic                  ready_i
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LEN_MAX  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   src_ptr;
  logic [ADDR_WIDTH-1:0]   dst_ptr;
  logic [ADDR_WIDTH:0]     count;

  logic                    xfer;
  logic [ADDR_WIDTH-1:0]   src_next;
  logic [ADDR_WIDTH-1:0]   dst_next;
  logic [ADDR_WIDTH:0]     len_clamped;

  assign xfer        = valid_o & ready_i;
  // Explicit wrap so a non power-of-two DEPTH still wraps at DEPTH-1.
  assign src_next    = (src_ptr == ADDR_MAX) ? '0 : src_ptr + 1'b1;
  assign dst_next    = (dst_ptr == ADDR_MAX) ? '0 : dst_ptr + 1'b1;
  assign len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;

`ifdef MEMCPY_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  logic [WAIT_W-1:0]            wait_cnt;
`else
  assign err_o = 1'b0;
`endif

  // wdata_o doubles as the read buffer: it is loaded on the read handshake
  // and presented unchanged through the following write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      count      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      valid_o    <= 1'b0;
      wr_rd_en_o <= 1'b0;
      addr_o     <= '0;
      wdata_o    <= '0;
`ifdef MEMCPY_TIMEOUT_EN
      err_o      <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      done_o <= 1'b0;
`ifdef MEMCPY_TIMEOUT_EN
      err_o  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start_i) begin
            src_ptr <= src_addr_i;
            dst_ptr <= dst_addr_i;
            count   <= len_clamped;
`ifdef MEMCPY_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (len_i == '0) begin
              // Empty command: finish without touching memory.
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state      <= S_RD;
              valid_o    <= 1'b1;
              wr_rd_en_o <= 1'b0;
              addr_o     <= src_addr_i;
              busy_o     <= 1'b1;
            end
          end
        end

        S_RD, S_WR: begin
          if (xfer) begin
`ifdef MEMCPY_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (state == S_RD) begin
              wdata_o    <= rdata_i;
              wr_rd_en_o <= 1'b1;
              addr_o     <= dst_ptr;
              state      <= S_WR;
            end else begin
              src_ptr <= src_next;
              dst_ptr <= dst_next;
              count   <= count - LEN_ONE;
              if (count == LEN_ONE) begin
                state      <= S_DONE;
                valid_o    <= 1'b0;
                wr_rd_en_o <= 1'b0;
                busy_o     <= 1'b0;
                done_o     <= 1'b1;
              end else begin
                // valid_o stays high: next read follows immediately.
                state      <= S_RD;
                wr_rd_en_o <= 1'b0;
                addr_o     <= src_next;
              end
            end
          end
`ifdef MEMCPY_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            // Responder never answered: abandon the copy, memory keeps
            // whatever words were already written.
            state      <= S_DONE;
            valid_o    <= 1'b0;
            wr_rd_en_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            err_o      <= 1'b1;
            wait_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_copy_master
//  Purpose  : Self-checking bench for mem_copy_master. A behavioural memory
//             responder answers requests; every request is compared against
//             a scoreboard queue filled from a reference copy model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_copy_master;

  localparam int W  = 16;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int DONE_LIMIT = 400;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          err;
  logic          valid;
  logic          wr_rd_en;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic          ready;

  mem_copy_master #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .src_addr_i (src_addr),
    .dst_addr_i (dst_addr),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .valid_o    (valid),
    .wr_rd_en_o (wr_rd_en),
    .addr_o     (addr),
    .wdata_o    (wdata),
    .rdata_i    (rdata),
    .ready_i    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder memory and the reference model of its contents.
  logic [W-1:0] mem   [0:D-1];
  logic [W-1:0] model [0:D-1];
  logic [W-1:0] snap  [0:D-1];

  assign rdata = mem[addr];

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [W-1:0]  data;
  } req_t;

  req_t exp_q[$];

  int vectors;
  int miscompares;
  int txn_cnt;
  int stall_n;
  bit force_low;
  bit idle_ready;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: strict ascending read-then-write, pointer wrap at D.
  task automatic push_expect(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l);
    int n;
    int ra;
    int wa;
    logic [W-1:0] v;
    n = (int'(l) > D) ? D : int'(l);
    for (int i = 0; i < n; i++) begin
      ra = (int'(s) + i) % D;
      wa = (int'(d) + i) % D;
      v  = model[ra];
      exp_q.push_back('{we: 1'b0, a: AW'(ra), data: '0});
      exp_q.push_back('{we: 1'b1, a: AW'(wa), data: v});
      model[wa] = v;
    end
  endtask

  task automatic sync_model();
    for (int i = 0; i < D; i++) model[i] = mem[i];
  endtask

  // Responder: decides ready for the coming edge, checks request stability
  // while stalled and pops the scoreboard on every handshake.
  initial begin : responder
    int            stall_cnt;
    bit            have_prev;
    logic [AW-1:0] prev_addr;
    logic          prev_we;
    logic [W-1:0]  prev_wdata;
    req_t          e;
    ready     = 1'b0;
    stall_cnt = 0;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst || force_low) begin
        ready = 1'b0;
      end else if (valid) begin
        if (stall_cnt < stall_n) begin
          ready = 1'b0;
          stall_cnt++;
        end else begin
          ready     = 1'b1;
          stall_cnt = 0;
        end
      end else begin
        ready     = idle_ready;
        stall_cnt = 0;
      end

      if (have_prev && valid) begin
        check_value("stall_addr", 32'(addr), 32'(prev_addr));
        check_value("stall_we", 32'(wr_rd_en), 32'(prev_we));
        if (prev_we) check_value("stall_wdata", 32'(wdata), 32'(prev_wdata));
      end
      have_prev  = valid && !ready && !rst;
      prev_addr  = addr;
      prev_we    = wr_rd_en;
      prev_wdata = wdata;

      if (valid && ready && !rst) begin
        txn_cnt++;
        if (exp_q.size() == 0) begin
          check_value("unexpected_req", 32'(addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_value("req_we", 32'(wr_rd_en), 32'(e.we));
          check_value("req_addr", 32'(addr), 32'(e.a));
          if (e.we) check_value("req_wdata", 32'(wdata), 32'(e.data));
        end
        if (wr_rd_en) mem[addr] = wdata;
      end
    end
  end

  // Issues one command and follows it to done_o. exp_cyc counts cycles from
  // the accepting edge (cycle 1 = first cycle after it).
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l,
                          input int exp_cyc, input bit exp_err, input bit inject);
    int cyc;
    push_expect(s, d, l);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    if (l != '0) begin
      check_value("first_valid", 32'(valid), 32'd1);
      check_value("first_addr", 32'(addr), 32'(s));
      check_value("first_we", 32'(wr_rd_en), 32'd0);
      check_value("busy", 32'(busy), 32'd1);
    end
    while (!done && cyc < DONE_LIMIT) begin
      if (inject && cyc == 3) begin
        src_addr = 5'd20;
        dst_addr = 5'd25;
        len      = 6'd5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      check_value("done_timeout", 32'(done), 32'd1);
    end else begin
      check_value("done_cycle", 32'(cyc), 32'(exp_cyc));
      check_value("err", 32'(err), 32'(exp_err));
      check_value("busy_in_done", 32'(busy), 32'd0);
      check_value("valid_in_done", 32'(valid), 32'd0);
    end
    if (!exp_err) check_value("sb_empty", 32'(exp_q.size()), 32'd0);
    else exp_q.delete();
    // A start presented in the DONE cycle must be ignored.
    src_addr = '0;
    dst_addr = 5'd1;
    len      = 6'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_value("post_done_valid", 32'(valid), 32'd0);
    check_value("post_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin : main
    int n;
    vectors     = 0;
    miscompares = 0;
    txn_cnt     = 0;
    stall_n     = 0;
    force_low   = 1'b1;
    idle_ready  = 1'b1;
    rst         = 1'b1;
    start       = 1'b0;
    src_addr    = '0;
    dst_addr    = '0;
    len         = '0;
    for (int i = 0; i < D; i++) mem[i] = W'($urandom);
    sync_model();

    repeat (3) @(negedge clk);
    check_value("rst_valid", 32'(valid), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_done", 32'(done), 32'd0);
    check_value("rst_err", 32'(err), 32'd0);
    check_value("rst_we", 32'(wr_rd_en), 32'd0);
    check_value("rst_addr", 32'(addr), 32'd0);
    check_value("rst_wdata", 32'(wdata), 32'd0);
    rst       = 1'b0;
    force_low = 1'b0;

    // Plain copy, ready tied high: done 1+2L cycles after the start edge.
    for (int i = 0; i < D; i++) snap[i] = mem[i];
    run_copy(5'd0, 5'd16, 6'd8, 17, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) check_value("t2_mem", 32'(mem[16+i]), 32'(snap[i]));

    // Ready stalls 3 cycles per request.
    for (int i = 0; i < D; i++) snap[i] = mem[i];
    stall_n = 3;
    run_copy(5'd4, 5'd8, 6'd4, 1 + 4 * 2 * 4, 1'b0, 1'b0);
    stall_n = 0;
    for (int i = 0; i < 4; i++) check_value("t3_mem", 32'(mem[8+i]), 32'(snap[4+i]));

    // Empty command and address wrap.
    n = txn_cnt;
    run_copy(5'd0, 5'd0, 6'd0, 1, 1'b0, 1'b0);
    check_value("len0_traffic", 32'(txn_cnt - n), 32'd0);
    for (int i = 0; i < D; i++) snap[i] = mem[i];
    run_copy(5'd30, 5'd2, 6'd4, 9, 1'b0, 1'b0);
    check_value("wrap_mem0", 32'(mem[2]), 32'(snap[30]));
    check_value("wrap_mem3", 32'(mem[5]), 32'(snap[1]));

    // Overlapping forward copy, plus a start while busy.
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
    sync_model();
    run_copy(5'd0, 5'd1, 6'd3, 7, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) check_value("overlap_mem", 32'(mem[i]), 32'd1);

    // Length above DEPTH is clamped to DEPTH.
    run_copy(5'd0, 5'd0, 6'd40, 1 + 2 * D, 1'b0, 1'b0);

    // Reset in the middle of a copy.
    push_expect(5'd8, 5'd20, 6'd8);
    @(negedge clk);
    src_addr = 5'd8;
    dst_addr = 5'd20;
    len      = 6'd8;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst       = 1'b1;
    force_low = 1'b1;
    @(negedge clk);
    check_value("midrst_valid", 32'(valid), 32'd0);
    check_value("midrst_busy", 32'(busy), 32'd0);
    check_value("midrst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    force_low = 1'b0;
    exp_q.delete();
    n = txn_cnt;
    repeat (10) begin
      @(negedge clk);
      if (done) check_value("midrst_no_done", 32'(done), 32'd0);
    end
    check_value("midrst_traffic", 32'(txn_cnt - n), 32'd0);
    check_value("midrst_valid_after", 32'(valid), 32'd0);
    sync_model();

    // Recovery after the aborted command.
    run_copy(5'd8, 5'd20, 6'd2, 5, 1'b0, 1'b0);

`ifdef MEMCPY_TIMEOUT_EN
    // Responder never answers: abort after 64 stalled cycles.
    force_low = 1'b1;
    run_copy(5'd3, 5'd12, 6'd2, 64 + 1, 1'b1, 1'b0);
    force_low = 1'b0;
    sync_model();
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
